// File: rtl/uart_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl_if
// Bundles the request side and the mux-control side of the UART TX
// sequencer.
//   master : drives the frame request (tx_start, tx_data, parity_en,
//            parity_odd) and observes the mux controls.
//   slave  : the sequencer; consumes the request and drives sel, en,
//            data_bit, parity_bit, busy and done.
// ---------------------------------------------------------------------------
interface uart_tx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 parity_en;
  logic                 parity_odd;
  logic [1:0]           sel;
  logic                 en;
  logic                 data_bit;
  logic                 parity_bit;
  logic                 busy;
  logic                 done;

  modport master (
    output tx_start, tx_data, parity_en, parity_odd,
    input  sel, en, data_bit, parity_bit, busy, done
  );

  modport slave (
    input  tx_start, tx_data, parity_en, parity_odd,
    output sel, en, data_bit, parity_bit, busy, done
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// Transmit-side sequencer for a UART output built from a 4:1 line mux
// (in_0 = 0 start, in_1 = data_bit, in_2 = parity_bit, in_3 = 1 stop/idle).
// Latches a byte on an accepted request, paces it at CLKS_PER_BIT clocks per
// bit and walks START -> DATA -> [PARITY] -> STOP.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : uart_tx_ctrl_if.slave
//            tx_start/tx_data/parity_en/parity_odd in, sampled in IDLE only
//            sel  (Gray: 00 START, 01 DATA, 11 PARITY, 10 STOP/IDLE)
//            en, data_bit (LSB first), parity_bit, busy, done out
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_en;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_par_en;
  logic                 r_parity;

  logic                 w_accept;
  logic                 w_bit_end;
  logic                 w_last_data;
  logic                 w_last_stop;
  logic [1:0]           w_sel;
  logic                 w_data_bit;
  logic                 w_busy;
  logic                 w_done;

  // Even parity is the XOR of the payload; odd parity is its complement.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d,
                                       input logic odd);
    return (^d) ^ odd;
  endfunction

  assign w_accept    = (r_state == S_IDLE) && bus.tx_start;
  assign w_bit_end   = (r_cnt == CNT_LAST);
  assign w_last_data = w_bit_end && (r_bit_idx == BIT_LAST);
  assign w_last_stop = w_bit_end && (r_stop_idx == STOP_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.tx_start) w_next = S_START;
      S_START:  if (w_bit_end)    w_next = S_DATA;
      S_DATA:   if (w_last_data)  w_next = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_bit_end)    w_next = S_STOP;
      S_STOP:   if (w_last_stop)  w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  // Output logic; the mux select is a pure function of state so it can only
  // move between Gray-adjacent codes, except DATA->STOP when parity is off.
  always_comb begin
    w_sel      = 2'b10;
    w_data_bit = 1'b1;
    w_busy     = (r_state != S_IDLE);
    w_done     = 1'b0;
    case (r_state)
      S_START:  w_sel = 2'b00;
      S_DATA: begin
        w_sel      = 2'b01;
        w_data_bit = r_shreg[0];
      end
      S_PARITY: w_sel = 2'b11;
      S_STOP: begin
        w_sel  = 2'b10;
        w_done = w_last_stop;
      end
      default:  w_sel = 2'b10;
    endcase
  end

  // Control registers: bit timing, bit/stop indices, latched frame options.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en       <= 1'b0;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_par_en   <= 1'b0;
      r_parity   <= 1'b0;
    end else begin
      r_en <= 1'b1;
      if (w_accept) begin
        r_cnt      <= '0;
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
        r_par_en   <= bus.parity_en;
        r_parity   <= calc_parity(bus.tx_data, bus.parity_odd);
      end else if (r_state != S_IDLE) begin
        r_cnt <= w_bit_end ? '0 : r_cnt + CNT_W'(1);
        if ((r_state == S_DATA) && w_bit_end) r_bit_idx  <= r_bit_idx + BIT_W'(1);
        if ((r_state == S_STOP) && w_bit_end) r_stop_idx <= r_stop_idx + 1'b1;
      end
    end
  end

  // Payload shift register; it is only observed during DATA, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept)
      r_shreg <= bus.tx_data;
    else if ((r_state == S_DATA) && w_bit_end)
      r_shreg <= {1'b0, r_shreg[DATA_BITS-1:1]};
  end

  assign bus.sel        = w_sel;
  assign bus.en         = r_en;
  assign bus.data_bit   = w_data_bit;
  assign bus.parity_bit = r_parity;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Directed bench for uart_tx_ctrl with CLKS_PER_BIT=4, DATA_BITS=8,
// STOP_BITS=1. Inputs change and outputs are sampled 1 time unit after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  localparam int CPB = 4;
  localparam int DB  = 8;
  localparam int SB  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx_ctrl_if #(.DATA_BITS(DB)) bus ();

  uart_tx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .STOP_BITS   (SB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc,
                     input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Observed status vector {sel, busy, done, en, parity_bit}.
  function automatic logic [7:0] obs_vec();
    return {2'b00, bus.sel, bus.busy, bus.done, bus.en, bus.parity_bit};
  endfunction

  // Sends one frame and checks every cycle of it.
  //   exp_par  : hand-computed parity bit for this frame
  //   inject_at: cycle (1-based after acceptance) at which a stray tx_start
  //              with different data is pulsed; 0 = none
  //   on_done  : also pulse tx_start on the done cycle
  //   rst_at   : cycle at which rst is pulsed for one clock; 0 = none
  task automatic run_frame(input logic [7:0] d, input logic pen, input logic podd,
                           input logic exp_par, input int inject_at,
                           input bit on_done, input int rst_at);
    int         len;
    int         phase;
    logic [1:0] esel;
    bit         aborted;
    len = (1 + DB + int'(pen) + SB) * CPB;
    bus.tx_data    = d;
    bus.parity_en  = pen;
    bus.parity_odd = podd;
    bus.tx_start   = 1'b1;
    tick();
    bus.tx_start   = 1'b0;
    // Changing the request inputs after acceptance must not affect the frame.
    bus.tx_data    = ~d;
    bus.parity_en  = ~pen;
    bus.parity_odd = ~podd;
    aborted = 1'b0;
    for (int c = 1; c <= len && !aborted; c++) begin
      phase = (c - 1) / CPB;
      if (phase == 0)                 esel = 2'b00;
      else if (phase <= DB)           esel = 2'b01;
      else if (pen && phase == DB + 1) esel = 2'b11;
      else                            esel = 2'b10;
      chk("frame", c, obs_vec(), {2'b00, esel, 1'b1, (c == len), 1'b1, exp_par});
      if (esel == 2'b01)
        chk("data_bit", c, {7'd0, bus.data_bit}, {7'd0, d[phase-1]});
      if (c == rst_at) begin
        rst = 1'b1;
        tick();
        chk("rst_vals", c, obs_vec(), {2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("rst_dbit", c, {7'd0, bus.data_bit}, 8'd1);
        rst = 1'b0;
        tick();
        chk("rst_rel", c, obs_vec(), {2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0});
        aborted = 1'b1;
      end else begin
        bus.tx_start = (c == inject_at) || (on_done && c == len);
        tick();
      end
    end
    bus.tx_start = 1'b0;
    if (!aborted) begin
      chk("idle1", len + 1, obs_vec(), {2'b00, 2'b10, 1'b0, 1'b0, 1'b1, exp_par});
      tick();
      chk("idle2", len + 2, obs_vec(), {2'b00, 2'b10, 1'b0, 1'b0, 1'b1, exp_par});
    end
  endtask

  initial begin
    bus.tx_start   = 1'b0;
    bus.tx_data    = 8'h00;
    bus.parity_en  = 1'b0;
    bus.parity_odd = 1'b0;
    rst            = 1'b1;

    // Reset held 3 cycles
    tick(); tick(); tick();
    chk("reset", 0, obs_vec(), {2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset_dbit", 0, {7'd0, bus.data_bit}, 8'd1);
    rst = 1'b0;
    tick();
    chk("en_release", 0, obs_vec(), {2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0});
    tick();

    // A5 = 1010_0101 has four ones: even parity 0, odd parity 1
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    run_frame(8'hA5, 1'b1, 1'b1, 1'b1, 0, 1'b0, 0);
    // No parity: 40-cycle frame, DATA goes straight to STOP
    run_frame(8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    // Stray tx_start mid-DATA (cycle 14) and on the done cycle are ignored;
    // 5A has four ones -> odd parity 1
    run_frame(8'h5A, 1'b0, 1'b1, 1'b1, 14, 1'b1, 0);
    // Next request in IDLE is accepted; C3 has four ones -> even parity 0
    run_frame(8'hC3, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    // Reset during PARITY (cycles 37..40)
    run_frame(8'hA5, 1'b1, 1'b1, 1'b1, 0, 1'b0, 38);
    // 3C has four ones -> odd parity 1
    run_frame(8'h3C, 1'b1, 1'b1, 1'b1, 0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
